// File: rtl/prog_feeder.sv
// Program source for the 8-bit control unit: loadable word memory plus a
// program counter that feeds instructions and immediates onto din.
module prog_feeder #(
   parameter int DEPTH = 16,
   parameter int AW    = 4,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          load_en,
   input  logic [AW-1:0] load_addr,
   input  logic [DW-1:0] load_data,
   input  logic [AW:0]   prog_len,
   input  logic          start,
   input  logic          abort,
   input  logic          ir_enable,
   input  logic [2:0]    cu_state,
   output logic [DW-1:0] din,
   output logic [AW:0]   pc,
   output logic          busy,
   output logic          done,
   output logic          err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_IMM,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
   localparam logic [AW:0] LP_ONE   = (AW+1)'(1);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [AW:0]   r_pc;
   logic [AW:0]   w_pc_nxt;
   logic          r_err;
   logic          w_err_nxt;
   logic          r_pend;
   logic          w_pend_nxt;
   logic [DW-1:0] r_mem [DEPTH];

   logic [AW:0]   w_eff_len;
   logic [AW:0]   w_pc_inc;
   logic [AW:0]   w_pc_imm;
   logic [DW-1:0] w_word;
   logic          w_in_range;
   logic          w_is_imm;
   logic          w_drive;

   assign w_eff_len  = (prog_len > LP_DEPTH) ? LP_DEPTH : prog_len;
   assign w_pc_inc   = r_pc + LP_ONE;
   assign w_word     = r_mem[r_pc[AW-1:0]];
   assign w_in_range = r_pc < w_eff_len;
   assign w_is_imm   = w_word[DW-1 -: 2] == 2'b01;
   assign w_pc_imm   = w_in_range ? w_pc_inc : r_pc;
   assign w_drive    = (r_state == S_FETCH) || (r_state == S_IMM);

   // Out-of-range reads drive 00, which the CU decodes as a harmless mv
   assign din  = (w_drive && w_in_range) ? w_word : '0;
   assign pc   = r_pc;
   assign busy = (r_state == S_FETCH) || (r_state == S_IMM) ||
                 (r_state == S_DRAIN);
   assign done = r_state == S_DONE;
   assign err  = r_err;

   always_ff @(posedge clk) begin
      if (load_en && !busy) begin
         r_mem[load_addr] <= load_data;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
         r_pc    <= '0;
         r_err   <= 1'b0;
         r_pend  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_err   <= w_err_nxt;
         r_pend  <= w_pend_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_err_nxt   = r_err;
      w_pend_nxt  = r_pend;
      if (abort) begin
         w_state_nxt = S_IDLE;
         w_pend_nxt  = 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  if (w_eff_len != '0) begin
                     w_pc_nxt    = '0;
                     w_err_nxt   = 1'b0;
                     w_state_nxt = S_FETCH;
                  end else begin
                     w_state_nxt = S_DONE;
                  end
               end
            end
            S_FETCH: begin
               if (ir_enable) begin
                  w_pc_nxt   = w_pc_inc;
                  w_pend_nxt = w_is_imm;
                  if (w_is_imm) begin
                     w_state_nxt = S_IMM;
                  end else if (w_pc_inc == w_eff_len) begin
                     w_state_nxt = S_DRAIN;
                  end
               end
            end
            S_IMM: begin
               // Immediate is consumed on the CU decode/execute edge
               if (r_pend && cu_state == 3'b010) begin
                  w_pc_nxt    = w_pc_imm;
                  w_err_nxt   = r_err | ~w_in_range;
                  w_pend_nxt  = 1'b0;
                  w_state_nxt = (w_pc_imm >= w_eff_len) ? S_DRAIN : S_FETCH;
               end
            end
            S_DRAIN: begin
               if (cu_state == 3'b000 && !ir_enable) begin
                  w_state_nxt = S_DONE;
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prog_feeder.sv
// Directed bench for prog_feeder: fetched words are checked against a
// queue of expected din values filled as each program is loaded.
module tb_prog_feeder;

   logic       clk = 1'b0;
   logic       resetn;
   logic       load_en;
   logic [3:0] load_addr;
   logic [7:0] load_data;
   logic [4:0] prog_len;
   logic       start;
   logic       abort;
   logic       ir_enable;
   logic [2:0] cu_state;
   logic [7:0] din;
   logic [4:0] pc;
   logic       busy;
   logic       done;
   logic       err;

   int total = 0;
   int bad   = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   prog_feeder #(.DEPTH(16), .AW(4), .DW(8)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .load_en   (load_en),
      .load_addr (load_addr),
      .load_data (load_data),
      .prog_len  (prog_len),
      .start     (start),
      .abort     (abort),
      .ir_enable (ir_enable),
      .cu_state  (cu_state),
      .din       (din),
      .pc        (pc),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s got=%h want=%h", tag, obs, expv);
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      load_en   = 1'b1;
      load_addr = a;
      load_data = d;
      step();
      load_en = 1'b0;
   endtask

   // Compare din with the next scoreboard entry, then acknowledge the fetch
   task automatic ack(input string tag);
      logic [7:0] e;
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $error("FAIL %s scoreboard empty got=%h", tag, din);
      end else begin
         e = exp_q.pop_front();
         chk(tag, din, e);
      end
      ir_enable = 1'b1;
      step();
      ir_enable = 1'b0;
   endtask

   initial begin
      #200000;
      $error("FAIL watchdog timeout total=%0d", total);
      $fatal(1);
   end

   initial begin
      resetn    = 1'b0;
      load_en   = 1'b0;
      load_addr = '0;
      load_data = '0;
      prog_len  = '0;
      start     = 1'b0;
      abort     = 1'b0;
      ir_enable = 1'b0;
      cu_state  = 3'b001;
      step();
      chk("rst_busy", {7'b0, busy}, 8'h00);
      chk("rst_done", {7'b0, done}, 8'h00);
      chk("rst_err", {7'b0, err}, 8'h00);
      chk("rst_pc", {3'b0, pc}, 8'h00);
      chk("rst_din", din, 8'h00);
      resetn = 1'b1;
      step();

      // 1: single plain instruction
      wr(4'd0, 8'h0A);
      prog_len = 5'd1;
      start = 1'b1;
      exp_q.push_back(8'h0A);
      step();
      start = 1'b0;
      chk("t1_busy", {7'b0, busy}, 8'h01);
      chk("t1_hold", din, 8'h0A);
      step();
      chk("t1_hold_pc", {3'b0, pc}, 8'h00);
      ack("t1_din");
      chk("t1_pc", {3'b0, pc}, 8'h01);
      chk("t1_drain_busy", {7'b0, busy}, 8'h01);
      cu_state = 3'b010;
      step();
      chk("t1_not_done", {7'b0, done}, 8'h00);
      cu_state = 3'b000;
      step();
      cu_state = 3'b001;
      chk("t1_done", {7'b0, done}, 8'h01);
      chk("t1_idle_busy", {7'b0, busy}, 8'h00);

      // 2: move-immediate with its operand
      wr(4'd0, 8'h58);
      wr(4'd1, 8'h5A);
      prog_len = 5'd2;
      start = 1'b1;
      exp_q.push_back(8'h58);
      exp_q.push_back(8'h5A);
      step();
      start = 1'b0;
      ack("t2_op");
      chk("t2_pc1", {3'b0, pc}, 8'h01);
      step();
      chk("t2_imm_hold", din, 8'h5A);
      exp_q.delete(0);
      cu_state = 3'b010;
      chk("t2_imm", din, 8'h5A);
      step();
      cu_state = 3'b001;
      chk("t2_pc2", {3'b0, pc}, 8'h02);
      chk("t2_busy", {7'b0, busy}, 8'h01);
      cu_state = 3'b000;
      step();
      cu_state = 3'b001;
      chk("t2_done", {7'b0, done}, 8'h01);
      chk("t2_err", {7'b0, err}, 8'h00);

      // 3: missing immediate
      prog_len = 5'd1;
      start = 1'b1;
      exp_q.push_back(8'h58);
      step();
      start = 1'b0;
      ack("t3_op");
      chk("t3_din0", din, 8'h00);
      chk("t3_err_pre", {7'b0, err}, 8'h00);
      cu_state = 3'b010;
      step();
      chk("t3_err", {7'b0, err}, 8'h01);
      chk("t3_pc", {3'b0, pc}, 8'h01);
      cu_state = 3'b000;
      step();
      cu_state = 3'b001;
      chk("t3_done", {7'b0, done}, 8'h01);
      chk("t3_err_keep", {7'b0, err}, 8'h01);

      // 4: empty program from IDLE
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("t4_idle_done", {7'b0, done}, 8'h00);
      prog_len = 5'd0;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("t4_done", {7'b0, done}, 8'h01);
      chk("t4_busy", {7'b0, busy}, 8'h00);

      // 5: abort beats start while in IMM
      prog_len = 5'd2;
      start = 1'b1;
      exp_q.push_back(8'h58);
      step();
      start = 1'b0;
      ack("t5_op");
      chk("t5_imm", din, 8'h5A);
      abort = 1'b1;
      start = 1'b1;
      step();
      abort = 1'b0;
      start = 1'b0;
      chk("t5_busy", {7'b0, busy}, 8'h00);
      chk("t5_done", {7'b0, done}, 8'h00);
      chk("t5_pc", {3'b0, pc}, 8'h01);
      wr(4'd3, 8'hC3);
      wr(4'd0, 8'h11);
      wr(4'd1, 8'h22);
      wr(4'd2, 8'h33);
      prog_len = 5'd4;
      start = 1'b1;
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h22);
      exp_q.push_back(8'h33);
      exp_q.push_back(8'hC3);
      step();
      start = 1'b0;
      for (int i = 0; i < 4; i++) ack("t5_run");
      chk("t5_pc4", {3'b0, pc}, 8'h04);
      cu_state = 3'b000;
      step();
      cu_state = 3'b001;
      chk("t5_end", {7'b0, done}, 8'h01);

      // 6: reset mid-FETCH, write while busy is dropped
      for (int i = 0; i < 6; i++) wr(4'(i), 8'h10 + 8'(i));
      wr(4'd6, 8'h66);
      prog_len = 5'd8;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 5; i++) exp_q.push_back(8'h10 + 8'(i));
      for (int i = 0; i < 5; i++) ack("t6_run");
      chk("t6_pc5", {3'b0, pc}, 8'h05);
      wr(4'd6, 8'hEE);
      #2;
      resetn = 1'b0;
      #1;
      chk("t6_busy", {7'b0, busy}, 8'h00);
      chk("t6_pc", {3'b0, pc}, 8'h00);
      chk("t6_done", {7'b0, done}, 8'h00);
      chk("t6_err", {7'b0, err}, 8'h00);
      chk("t6_din", din, 8'h00);
      step();
      resetn = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 6; i++) exp_q.push_back(8'h10 + 8'(i));
      exp_q.push_back(8'h66);
      for (int i = 0; i < 7; i++) ack("t6_rerun");
      chk("t6_pc7", {3'b0, pc}, 8'h07);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("t6_abort", {7'b0, busy}, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
